// File: rtl/exec_wb_pkg.sv
// Shared definitions for the execute/write-back stage: opcode and funct
// encodings of the supported RV32I ALU subset, the ALU operation type, the
// decoded control bundle and small decode helpers.
package exec_wb_pkg;

    // Register file geometry
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    // Major opcodes
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    // funct3 codes shared by the register-register and register-immediate forms
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    // funct7 codes (register-register form only)
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_SLT
    } alu_op_t;

    // Decoded control for one instruction
    typedef struct packed {
        alu_op_t op;
        logic    use_imm;   // operand B is the sign-extended immediate
        logic    legal;     // instruction belongs to the supported subset
    } ctrl_t;

    // True when funct3 names one of the supported ALU operations
    function automatic logic f3_supported(input logic [2:0] f3);
        return (f3 == F3_ADD) || (f3 == F3_SLT) || (f3 == F3_XOR) ||
               (f3 == F3_OR)  || (f3 == F3_AND);
    endfunction

    // Base ALU operation for a funct3 code (subtract is selected by funct7)
    function automatic alu_op_t f3_to_op(input logic [2:0] f3);
        alu_op_t op;
        case (f3)
            F3_SLT:  op = ALU_SLT;
            F3_XOR:  op = ALU_XOR;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Sign-extend a 12-bit I-type immediate
    function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
        return {{(XLEN-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/exec_wb_regfile.sv
// 32x32 integer register file: two asynchronous operand read ports, one
// asynchronous debug read port and one synchronous write port. x0 is
// hardwired to zero on every read port and never written.
module exec_wb_regfile
    import exec_wb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    input  logic [REG_AW-1:0] ra_dbg,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [XLEN-1:0]   wd,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2,
    output logic [XLEN-1:0]   rd_dbg
);

    logic [XLEN-1:0] mem [NREGS];

    // Write port: clear everything on reset, otherwise write any register but x0
    // NOTE: this array is reset on purpose because every register must read
    // zero after reset; that forces flops instead of a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    // Read ports: no write-through, so a same-cycle write is seen after the edge
    assign rd1    = (ra1    == '0) ? '0 : mem[ra1];
    assign rd2    = (ra2    == '0) ? '0 : mem[ra2];
    assign rd_dbg = (ra_dbg == '0) ? '0 : mem[ra_dbg];

endmodule

// File: rtl/exec_wb_stage.sv
// Execute / write-back stage for the RV32I register-register and
// register-immediate ALU subset. EX reads operands and computes the result in
// the cycle the instruction is presented; the result is registered into WB and
// written to the register file at the end of the WB cycle. A single WB-to-EX
// bypass covers the back-to-back dependence.
module exec_wb_stage
    import exec_wb_pkg::*;
#(
    parameter int RET_W  = 16,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       instr,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [11:0]       imm,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              illegal,
    input  logic [4:0]        dbg_addr,
    output logic [31:0]       dbg_data,
    output logic [RET_W-1:0]  retired
);

    // Instruction fields used for decode; register numbers and the immediate
    // come from the decoder ports instead.
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    ctrl_t           ctrl;
    logic [XLEN-1:0] rf_a;
    logic [XLEN-1:0] rf_b;
    logic            fwd_a;
    logic            fwd_b;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;

    // ------------------------------------------------------------------
    // Register file; written from the WB stage, read by EX and debug
    // ------------------------------------------------------------------
    exec_wb_regfile u_regfile (
        .clk    (clk),
        .reset  (reset),
        .ra1    (rs1),
        .ra2    (rs2),
        .ra_dbg (dbg_addr),
        .we     (wb_we),
        .wa     (wb_rd),
        .wd     (wb_data),
        .rd1    (rf_a),
        .rd2    (rf_b),
        .rd_dbg (dbg_data)
    );

    // Decode opcode/funct3/funct7 into an ALU operation and legality flag
    // NOTE: every field gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        ctrl = '{op: ALU_ADD, use_imm: 1'b0, legal: 1'b0};
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE) begin
                    ctrl.legal = f3_supported(funct3);
                    ctrl.op    = f3_to_op(funct3);
                end else if ((funct7 == F7_SUB) && (funct3 == F3_ADD)) begin
                    ctrl.legal = 1'b1;
                    ctrl.op    = ALU_SUB;
                end
            end
            OP_I: begin
                ctrl.use_imm = 1'b1;
                ctrl.legal   = f3_supported(funct3);
                ctrl.op      = f3_to_op(funct3);
            end
            default: ;
        endcase
    end

    // Bypass: a source that names the register WB is about to write takes
    // wb_data, since the register file only updates at the end of this cycle.
    // wb_we is never set for x0, so x0 is never bypassed.
    assign fwd_a = FWD_EN && in_valid && wb_we && (wb_rd != '0) && (rs1 == wb_rd);
    assign fwd_b = FWD_EN && in_valid && wb_we && (wb_rd != '0) && (rs2 == wb_rd);

    // Operand selection: bypass or register file for A; immediate or register for B
    always_comb begin
        op_a = fwd_a ? wb_data : rf_a;
        op_b = fwd_b ? wb_data : rf_b;
        if (ctrl.use_imm) begin
            op_b = sext12(imm);
        end
    end

    // ALU: 32-bit wraparound arithmetic, signed set-less-than
    always_comb begin
        alu_res = '0;
        case (ctrl.op)
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_AND: alu_res = op_a & op_b;
            ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_res = '0;
        endcase
    end

    // EX -> WB pipeline register; an idle cycle clears the flags but holds rd/data
    // NOTE: state is updated with non-blocking assignments so every flop in
    // this block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            illegal  <= 1'b0;
        end else if (in_valid) begin
            wb_valid <= 1'b1;
            wb_we    <= ctrl.legal && (rd != '0);
            wb_rd    <= rd;
            wb_data  <= ctrl.legal ? alu_res : '0;
            illegal  <= !ctrl.legal;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            illegal  <= 1'b0;
        end
    end

    // Retired counter: one count per WB cycle holding an instruction, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired <= '0;
        end else if (wb_valid) begin
            retired <= retired + RET_W'(1);
        end
    end

endmodule

// File: doc/exec_wb_stage.md
Name: exec_wb_stage

Overview:
- Stage directly downstream of the fetch/decode path.
- Consumes each fetched instruction word plus its decoded fields (rd, rs1, rs2, imm).
- Reads a 32x32 integer register file, executes the RV32I register-register and register-immediate ALU subset, and writes the result back.
- Two-stage pipeline (EX, WB) with one forwarding path, a debug read port and a retired-instruction counter.

Parameters:
- RET_W, 16, width of retired-instruction counter
- FWD_EN, 1, 1 = WB-to-EX forwarding enabled; 0 = no forwarding (bench/diagnostic use only)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction/fields valid this cycle
- instr  in  32  full instruction word (opcode [6:0], funct3 [14:12], funct7 [31:25])
- rd  in  5  destination register from decoder
- rs1  in  5  source register 1 from decoder
- rs2  in  5  source register 2 from decoder
- imm  in  12  I-type immediate from decoder
- wb_valid  out  1  WB stage holds a retired instruction
- wb_we  out  1  register-file write occurs at end of this cycle
- wb_rd  out  5  WB destination
- wb_data  out  32  WB result
- illegal  out  1  one-cycle pulse: unsupported instruction retired
- dbg_addr  in  5  debug read address
- dbg_data  out  32  combinational register-file read of dbg_addr (x0 reads 0)
- retired  out  RET_W  count of valid instructions retired (legal and illegal)

Behaviour:
- Reset (async, active-high): all 32 registers, wb_valid, wb_we, wb_rd, wb_data, illegal and retired cleared to 0. Reset mid-pipeline discards the in-flight instruction; no write occurs.
- Cycle N, in_valid=1:
  - Operands are read combinationally.
  - Operand A = regfile[rs1]; operand B = regfile[rs2] for R-type, or sign-extended imm for I-type.
  - ALU result is registered into the WB stage at the N edge.
- Cycle N+1:
  - wb_valid=1; wb_rd and wb_data present the result.
  - Register file is written at the end of N+1 when wb_we=1.
- Latency: 1 cycle from input to wb_*; 2 edges until the value is architecturally visible in regfile/dbg_data.
- Forwarding (FWD_EN=1):
  - Condition: in_valid && wb_we && wb_rd!=0 && (rs1==wb_rd or rs2==wb_rd).
  - Action: the matching operand takes wb_data instead of regfile.
  - Instruction in N+2 reads the written regfile; no further bypass is needed.
- FWD_EN=0: operands always come from regfile (stale by 1 cycle on back-to-back dependence).
- Supported operations:
  - opcode 0110011: funct3/funct7 ADD(000/0000000), SUB(000/0100000), XOR(100), OR(110), AND(111), SLT(010, signed).
  - opcode 0010011: ADDI, XORI, ORI, ANDI, SLTI (same funct3 codes).
- Arithmetic: 32-bit wraparound, no overflow flag. SLT/SLTI yield 32'd1 or 32'd0.
- Unsupported opcode/funct (incl. 0x00000000):
  - wb_valid=1, wb_we=0, wb_data=0, illegal=1 for that WB cycle.
  - Counted in retired.
- rd==0: wb_valid=1, wb_we=0 (write dropped); x0 always reads 0 on all read ports.
- in_valid=0: next cycle wb_valid=0, wb_we=0, illegal=0; wb_rd/wb_data hold their previous values.
- retired increments on each wb_valid cycle and wraps from all-ones to 0.
- Simultaneous dbg read and WB write to the same register: dbg_data shows the old value until the edge (no bypass on the debug port).

Decomposition:
- Shared package holds:
  - opcode constants OP_R=7'b0110011 and OP_I=7'b0010011
  - funct3 codes F3_ADD, F3_SLT, F3_XOR, F3_OR, F3_AND
  - funct7 codes F7_BASE, F7_SUB
  - alu_op enumerated type
- One natural sub-module: exec_wb_regfile (32x32, two async read ports plus debug read, one sync write port, x0 hardwired, async reset clear).
- ALU and decode control stay inline.

Test Plan:
- Reset mid-run, then release → all outputs 0; dbg_data=0 for every address; retired=0.
- ADDI x1,x0,5 (0x00500093), then idle → cycle+1: wb_valid=1, wb_we=1, wb_rd=1, wb_data=5; after 2 edges dbg_addr=1 gives dbg_data=5.
- Back-to-back ADDI x1,x0,7; ADD x2,x1,x1 (0x00108133) → wb_data=14 for x2 via forwarding. With FWD_EN=0 → x2 gets 2×(old x1)=0.
- ADDI x3,x0,-1 (imm=0xFFF); SLTI x4,x3,0 → x3=0xFFFFFFFF, x4=1; SUB x5,x0,x3 → x5=1.
- ADDI x0,x0,9, then instr=0xFFFFFFFF → both produce wb_valid=1, wb_we=0; second also gives illegal=1; x0 still reads 0; retired +2.
- RET_W=4, 17 valid instructions → retired wraps to 1.
